// File: rtl/vx_gpu_pkg.sv
// Shared CSR definitions for the SFU CSR path.
// The package holds the CSR operation encoding and the read-only address decode.
package vx_gpu_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_e;

  // Encoding 3 is not a valid CSR operation and is reported as illegal.
  localparam logic [1:0] CSR_OP_BAD = 2'd3;

  // Addresses whose top two bits are both set belong to the read-only CSR space.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/vx_csr_rmw_ctrl.sv
// CSR read-modify-write initiator: read the CSR, compute the new value, write it back, return the old value.
// One request is in flight at a time. The response payload lives in this FSM's own registers.
module vx_csr_rmw_ctrl
  import vx_gpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 12,
  parameter int UUID_W    = 44,
  parameter int NW_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [UUID_W-1:0]    req_uuid,
  input  logic [NW_W-1:0]      req_wid,
  input  logic [1:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [XLEN-1:0]      req_src,
  input  logic                 req_no_read,
  input  logic                 req_no_write,
  output logic                 read_enable,
  output logic [UUID_W-1:0]    read_uuid,
  output logic [NW_W-1:0]      read_wid,
  output logic [ADDR_BITS-1:0] read_addr,
  input  logic [XLEN-1:0]      read_data_ro,
  input  logic [XLEN-1:0]      read_data_rw,
  output logic                 write_enable,
  output logic [UUID_W-1:0]    write_uuid,
  output logic [NW_W-1:0]      write_wid,
  output logic [ADDR_BITS-1:0] write_addr,
  output logic [XLEN-1:0]      write_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [UUID_W-1:0]    rsp_uuid,
  output logic [NW_W-1:0]      rsp_wid,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   init_q, init_d;
  logic [UUID_W-1:0]      uuid_q, uuid_d;
  logic [NW_W-1:0]        wid_q, wid_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]        src_q, src_d;
  logic [XLEN-1:0]        old_q, old_d;
  logic                   no_read_q, no_read_d;
  logic                   do_write_q, do_write_d;
  logic                   illegal_q, illegal_d;
  logic                   req_ill;
  logic [XLEN-1:0]        wval;

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_d     = 1'b1;
    uuid_d     = uuid_q;
    wid_d      = wid_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    old_d      = old_q;
    no_read_d  = no_read_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;

    // req_ready stays low until the first clock after reset is released.
    req_ready    = (state_q == ST_IDLE) && init_q;
    read_enable  = 1'b0;
    read_uuid    = '0;
    read_wid     = '0;
    read_addr    = '0;
    write_enable = 1'b0;
    write_uuid   = '0;
    write_wid    = '0;
    write_addr   = '0;
    write_data   = '0;
    rsp_valid    = 1'b0;
    rsp_uuid     = '0;
    rsp_wid      = '0;
    rsp_data     = '0;
    rsp_illegal  = 1'b0;

    req_ill = (csr_is_ro(req_addr[11:0]) && !req_no_write) || (req_op == CSR_OP_BAD);

    case (op_q)
      CSR_RW:  wval = src_q;
      CSR_RS:  wval = old_q | src_q;
      default: wval = old_q & ~src_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          uuid_d     = req_uuid;
          wid_d      = req_wid;
          op_d       = req_op;
          addr_d     = req_addr;
          src_d      = req_src;
          no_read_d  = req_no_read;
          illegal_d  = req_ill;
          do_write_d = !req_no_write && !req_ill;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (!no_read_q) begin
          read_enable = 1'b1;
          read_uuid   = uuid_q;
          read_wid    = wid_q;
          read_addr   = addr_q;
        end
        old_d   = no_read_q ? '0 : (read_data_ro | read_data_rw);
        state_d = do_write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        write_enable = 1'b1;
        write_uuid   = uuid_q;
        write_wid    = wid_q;
        write_addr   = addr_q;
        write_data   = wval;
        state_d      = ST_RESP;
      end
      default: begin
        rsp_valid   = 1'b1;
        rsp_uuid    = uuid_q;
        rsp_wid     = wid_q;
        rsp_data    = old_q;
        rsp_illegal = illegal_q;
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, and every register is cleared on reset so no stale payload can reach an output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b0;
      uuid_q     <= '0;
      wid_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      old_q      <= '0;
      no_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      uuid_q     <= uuid_d;
      wid_q      <= wid_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      old_q      <= old_d;
      no_read_q  <= no_read_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule
